cnot_ladder_decoder: RTL and testbench



---
 rtl/cnot_pkg.sv | 33 +++
 rtl/cnot_slice_decode.sv | 37 +++
 rtl/cnot_ladder_decoder.sv | 152 +++++++++++++++
 tb/tb_cnot_ladder_decoder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnot_pkg
// Purpose  : Shared types, default sizes and the forward CNOT ladder encoder
//            for the cnot_ladder_decoder block.
// Contents : state_t       - decoder FSM states (IDLE, DECODE, DONE)
//            DEF_WIDTH     - default word width
//            DEF_STEP      - default bits decoded per clock
//            cnot_ladder_encode(word) - forward ladder, y[i]=x[i]^x[i+1]
// Revision : 1.0 - initial release
// ============================================================================
package cnot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_STEP       = 4;
  localparam int CNOT_MAX_WIDTH = 64;

  // Callers zero-extend narrower words; the implicit x[W]=0 makes the MSB
  // pass through unchanged, matching y[W-1]=x[W-1].
  function automatic logic [CNOT_MAX_WIDTH-1:0] cnot_ladder_encode(
    input logic [CNOT_MAX_WIDTH-1:0] word
  );
    return word ^ (word >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnot_slice_decode.sv
`default_nettype none
// ============================================================================
// Module   : cnot_slice_decode
// Purpose  : Combinational STEP-bit prefix-XOR slice, MSB first.
// Ports    : y_slice   (in,  STEP) encoded bits of this slice
//            carry_in  (in,  1)    decoded bit just above the slice
//            x_slice   (out, STEP) decoded bits
//            carry_out (out, 1)    LSB of x_slice, feeds the next slice
// Revision : 1.0 - initial release
// ============================================================================
module cnot_slice_decode
  import cnot_pkg::*;
#(
  parameter int STEP = DEF_STEP
) (
  input  logic [STEP-1:0] y_slice,
  input  logic            carry_in,
  output logic [STEP-1:0] x_slice,
  output logic            carry_out
);

  logic w_run;

  // x[i] = y[i] ^ x[i+1]: a running parity walking down from the MSB.
  always_comb begin
    w_run   = carry_in;
    x_slice = '0;
    for (int i = STEP - 1; i >= 0; i--) begin
      w_run      = w_run ^ y_slice[i];
      x_slice[i] = w_run;
    end
  end

  assign carry_out = x_slice[0];

endmodule
`default_nettype wire

// File: rtl/cnot_ladder_decoder.sv
`default_nettype none
// ============================================================================
// Module   : cnot_ladder_decoder
// Purpose  : Multi-cycle inverse of the CNOT ladder encoding; recovers x from
//            y with a prefix XOR, STEP bits per clock, MSB first.
// Ports    : clk, rst_n (async, active-low)
//            in_data/in_valid/in_ready    - encoded word input handshake
//            out_data/out_valid/out_ready - decoded word output handshake
//            busy                         - high in DECODE or DONE
//            check_err (CNOT_LADDER_CHECK_EN only) - sticky self-check error
// Options  : `define CNOT_LADDER_CHECK_EN adds a re-encode self-check in DONE.
// Revision : 1.0 - initial release
// ============================================================================
module cnot_ladder_decoder
  import cnot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef CNOT_LADDER_CHECK_EN
  ,
  output logic             check_err
`endif
);

  localparam int NSTEP = WIDTH / STEP;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_out;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [STEP-1:0]  w_y_slice;
  logic [STEP-1:0]  w_x_slice;
  logic             w_carry_out;
  logic             w_last;

  // Slice k covers bits WIDTH-1-k*STEP downto WIDTH-(k+1)*STEP.
  always_comb begin
    w_y_slice = '0;
    for (int k = 0; k < NSTEP; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_y_slice = r_shadow[WIDTH-1-k*STEP -: STEP];
      end
    end
  end

  assign w_last = (r_cnt == CNT_W'(NSTEP - 1));

  cnot_slice_decode #(
    .STEP (STEP)
  ) u_slice (
    .y_slice   (w_y_slice),
    .carry_in  (r_carry),
    .x_slice   (w_x_slice),
    .carry_out (w_carry_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = DECODE;
      end
      DECODE: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // An in_valid seen here is deliberately not consumed.
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_out    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shadow <= in_data;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
          end
        end
        DECODE: begin
          for (int k = 0; k < NSTEP; k++) begin
            if (r_cnt == CNT_W'(k)) begin
              r_out[WIDTH-1-k*STEP -: STEP] <= w_x_slice;
            end
          end
          r_carry <= w_carry_out;
          r_cnt   <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_out;

`ifdef CNOT_LADDER_CHECK_EN
  logic [CNOT_MAX_WIDTH-1:0] w_reenc;
  logic                      r_check_err;

  // A correct decode re-encodes to exactly the latched input word.
  assign w_reenc = cnot_ladder_encode(CNOT_MAX_WIDTH'(r_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_check_err <= 1'b0;
    end else if (r_state == DONE && w_reenc != CNOT_MAX_WIDTH'(r_shadow)) begin
      r_check_err <= 1'b1;
    end
  end

  assign check_err = r_check_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnot_ladder_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnot_ladder_decoder
// Purpose  : Self-checking bench for cnot_ladder_decoder (WIDTH=16, STEP=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnot_ladder_decoder;
  import cnot_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef CNOT_LADDER_CHECK_EN
  logic        check_err;
`endif

  int checks = 0;
  int errors = 0;

  cnot_ladder_decoder #(
    .WIDTH (16),
    .STEP  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef CNOT_LADDER_CHECK_EN
    ,
    .check_err (check_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference: x[i] = y[i] ^ x[i+1] with x[16]=0, i.e. parity of y[15:i].
  function automatic logic [15:0] ref_decode(input logic [15:0] y);
    logic [15:0] x;
    logic        acc;
    acc = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      acc  = acc ^ y[i];
      x[i] = acc;
    end
    return x;
  endfunction

  function automatic logic [15:0] ref_encode(input logic [15:0] x);
    logic [63:0] t;
    t = cnot_ladder_encode({48'd0, x});
    return t[15:0];
  endfunction

  // Sends one word with out_ready high; returns decoded word and latency.
  task automatic run_word(input logic [15:0] y, output logic [15:0] x,
                          output int lat, output bit ok);
    int g;
    ok = 1'b1;
    lat = 0;
    g = 0;
    @(negedge clk);
    in_data = y; in_valid = 1'b1; out_ready = 1'b1;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    if (!in_ready) ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!out_valid) ok = 1'b0;
    x = out_data;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    int first = -1;
    int bc = 0;
    logic [15:0] x = '0;
    @(negedge clk);
    in_data = 16'h8000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 0) in_valid = 1'b0;
      if (busy) bc++;
      if (out_valid && first < 0) begin first = n; x = out_data; end
    end
    checks += 3;
    if (first != 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", first); end
    if (bc != 5) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 5", bc); end
    if (x !== 16'hFFFF) begin errors++; $display("FAIL basic_data: got %h expected ffff", x); end
  endtask

  task automatic test_vectors();
    logic [15:0] ys [5] = '{16'hC000, 16'h0001, 16'h0000, 16'hA5A5, 16'h7FFE};
    logic [15:0] xs [5] = '{16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] x;
    int lat;
    bit ok;
    xs[3] = ref_decode(16'hA5A5);
    xs[4] = ref_decode(16'h7FFE);
    for (int i = 0; i < 5; i++) begin
      run_word(ys[i], x, lat, ok);
      checks += 2;
      if (!ok || x !== xs[i]) begin
        errors++; $display("FAIL vector_%0d_data: got %h expected %h (ok=%0d)", i, x, xs[i], ok);
      end
      if (lat != 4) begin errors++; $display("FAIL vector_%0d_latency: got %0d expected 4", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp1 = ref_decode(16'h5555);
    logic [15:0] exp2 = ref_decode(16'h1234);
    int g = 0;
    @(negedge clk);
    in_data = 16'h5555; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && g < 50) begin @(negedge clk); g++; end
    checks++;
    if (!out_valid) begin errors++; $display("FAIL bp_reach_done: got out_valid=0 expected 1"); end
    in_data = 16'h1234; in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++;
      if (out_data !== exp1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: got data=%h in_ready=%b out_valid=%b expected %h/0/1",
                 n, out_data, in_ready, out_valid, exp1);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release_idle: got in_ready=%b busy=%b out_valid=%b expected 1/0/0",
                         in_ready, busy, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_accept_held: got busy=%b expected 1", busy); end
    g = 0;
    while (!out_valid && g < 50) begin @(negedge clk); g++; end
    checks++;
    if (out_data !== exp2 || !out_valid) begin
      errors++; $display("FAIL bp_held_word: got %h expected %h", out_data, exp2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] x;
    int lat;
    bit ok;
    @(negedge clk);
    in_data = 16'hABCD; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== 16'h0000) begin
      errors++; $display("FAIL mid_reset: got out_valid=%b in_ready=%b busy=%b data=%h expected 0/1/0/0000",
                         out_valid, in_ready, busy, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_word(16'h8000, x, lat, ok);
    checks++;
    if (!ok || x !== 16'hFFFF || lat != 4) begin
      errors++; $display("FAIL after_mid_reset: got %h lat %0d expected ffff lat 4", x, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_q[$];
    logic [15:0] cur_x = '0;
    logic [15:0] e;
    bit have = 1'b0;
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    while (recv < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (!have && sent < 1000 && $urandom_range(0, 3) != 0) begin
        cur_x = 16'($urandom);
        have = 1'b1;
      end
      in_valid = have;
      in_data = have ? ref_encode(cur_x) : 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_x);
        sent++;
        have = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL random_extra_output: got %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++; $display("FAIL random_word_%0d: got %h expected %h", recv, out_data, e);
          end
        end
        recv++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (recv != 1000 || exp_q.size() != 0) begin
      errors++; $display("FAIL random_count: got recv=%0d pending=%0d expected 1000/0", recv, exp_q.size());
    end
  endtask

`ifdef CNOT_LADDER_CHECK_EN
  task automatic test_check();
    logic [15:0] sv;
    logic [15:0] fv;
    logic [15:0] x;
    int lat;
    bit ok;
    int g = 0;
    checks++;
    if (check_err !== 1'b0) begin errors++; $display("FAIL check_clean: got %b expected 0", check_err); end
    @(negedge clk);
    in_data = ref_encode(16'h3C3C); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && g < 50) begin @(negedge clk); g++; end
    checks++;
    if (check_err !== 1'b0 || out_data !== 16'h3C3C) begin
      errors++; $display("FAIL check_done_clean: got err=%b data=%h expected 0/3c3c", check_err, out_data);
    end
    sv = dut.r_shadow;
    fv = sv ^ 16'h0010;
    force dut.r_shadow = fv;
    @(negedge clk);
    checks++;
    if (check_err !== 1'b1) begin errors++; $display("FAIL check_fault_set: got %b expected 1", check_err); end
    release dut.r_shadow;
    out_ready = 1'b1;
    @(negedge clk);
    run_word(ref_encode(16'h0F0F), x, lat, ok);
    checks++;
    if (check_err !== 1'b1) begin errors++; $display("FAIL check_sticky: got %b expected 1", check_err); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (check_err !== 1'b0) begin errors++; $display("FAIL check_reset_clear: got %b expected 0", check_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef CNOT_LADDER_CHECK_EN
    test_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
